// File: rtl/wave_buffer_if.sv
// wave_buffer_if: AD sample stream, renderer read port and frame handshake
// grouped into one bundle.
//   ad_data/ad_valid   : 8-bit AD sample and its strobe
//   data_req/line_cnt  : renderer read request and column index
//   wr_over            : renderer frame-complete pulse
//   line_length        : front-bank sample, zero-extended to 16 bits
//   wave_ready         : back bank holds a complete capture awaiting swap
//   trig_flag          : last swapped-in capture came from a real trigger
interface wave_buffer_if;
  logic [7:0]  ad_data;
  logic        ad_valid;
  logic        data_req;
  logic [8:0]  line_cnt;
  logic        wr_over;
  logic [15:0] line_length;
  logic        wave_ready;
  logic        trig_flag;

  // Sample source / renderer side
  modport master (
    output ad_data, ad_valid, data_req, line_cnt, wr_over,
    input  line_length, wave_ready, trig_flag
  );

  // Acquisition buffer side
  modport slave (
    input  ad_data, ad_valid, data_req, line_cnt, wr_over,
    output line_length, wave_ready, trig_flag
  );
endinterface

// File: rtl/wave_buffer.sv
// wave_buffer: double-buffered oscilloscope acquisition. Captures AD samples
// into the back bank with a pre-trigger window, level/edge trigger and
// auto-trigger timeout; swaps banks on the renderer's frame-done pulse and
// serves the front bank with one-cycle read latency.
// Ports:
//   lcd_clk    : sole clock
//   sys_rst    : synchronous active-high reset
//   run_stop   : 1 = acquire, 0 = freeze display and abort capture
//   trig_level : trigger threshold
//   trig_edge  : 0 = rising, 1 = falling
//   bus        : sample stream, renderer read port and status (slave side)
module wave_buffer #(
  parameter int unsigned DEPTH    = 300,
  parameter int unsigned PRE_TRIG = 150,
  parameter int unsigned AUTO_TO  = 4000
) (
  input  logic         lcd_clk,
  input  logic         sys_rst,
  input  logic         run_stop,
  input  logic [7:0]   trig_level,
  input  logic         trig_edge,
  wave_buffer_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned AW1      = AW + 1;
  localparam int unsigned TW       = $clog2(AUTO_TO + 1);
  localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;

  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, FULL} state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] taddr;
  logic [AW-1:0] start;
  logic [AW-1:0] cnt;
  logic [TW-1:0] auto_cnt;
  logic [7:0]    prev;
  logic          front;
  logic          front_valid;
  logic          tflag_pend;
  logic          wave_ready;
  logic          trig_flag;
  logic [15:0]   line_length;

  logic [7:0] bank0 [DEPTH];
  logic [7:0] bank1 [DEPTH];

  logic          we_c;
  logic          cross_c;
  logic [AW-1:0] wptr_nxt_c;
  logic [AW-1:0] rd_idx_c;
  logic [AW1-1:0] rd_sum_c;
  logic [AW-1:0] rd_addr_c;
  logic [AW-1:0] start_nxt_c;

  assign bus.line_length = line_length;
  assign bus.wave_ready  = wave_ready;
  assign bus.trig_flag   = trig_flag;

  // Write strobe, trigger detect and mod-DEPTH address arithmetic
  always_comb begin
    we_c        = 1'b0;
    cross_c     = 1'b0;
    wptr_nxt_c  = '0;
    rd_idx_c    = '0;
    rd_sum_c    = '0;
    rd_addr_c   = '0;
    start_nxt_c = '0;

    we_c = run_stop && bus.ad_valid &&
           (state == PREFILL || state == ARMED || state == POST);

    wptr_nxt_c = (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);

    if (trig_edge)
      cross_c = (prev > trig_level) && (trig_level >= bus.ad_data);
    else
      cross_c = (prev < trig_level) && (trig_level <= bus.ad_data);

    // Clamp out-of-range columns to the last one
    rd_idx_c  = (32'(bus.line_cnt) > DEPTH - 1) ? AW'(DEPTH - 1) : AW'(bus.line_cnt);
    rd_sum_c  = AW1'(start) + AW1'(rd_idx_c);
    rd_addr_c = (rd_sum_c >= AW1'(DEPTH)) ? AW'(rd_sum_c - AW1'(DEPTH)) : AW'(rd_sum_c);

    // Window start = taddr - PRE_TRIG, wrapped into 0..DEPTH-1
    start_nxt_c = (taddr >= AW'(PRE_TRIG)) ? taddr - AW'(PRE_TRIG)
                                           : taddr + AW'(DEPTH - PRE_TRIG);
  end

  // Capture always lands in the bank the renderer is not reading
  always_ff @(posedge lcd_clk) begin
    if (we_c) begin
      if (front) bank0[wptr] <= bus.ad_data;
      else       bank1[wptr] <= bus.ad_data;
    end
  end

  // Registered read port; midline until a capture has been swapped in
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      line_length <= 16'd128;
    end else if (bus.data_req) begin
      if (!front_valid)
        line_length <= 16'd128;
      else
        line_length <= {8'd0, (front ? bank1[rd_addr_c] : bank0[rd_addr_c])};
    end
  end

  // Capture FSM
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      wptr        <= '0;
      taddr       <= '0;
      start       <= '0;
      cnt         <= '0;
      auto_cnt    <= '0;
      prev        <= '0;
      front       <= 1'b0;
      front_valid <= 1'b0;
      tflag_pend  <= 1'b0;
      wave_ready  <= 1'b0;
      trig_flag   <= 1'b0;
    end else if (!run_stop) begin
      // Abort capture; display-side state is left frozen
      state      <= IDLE;
      wave_ready <= 1'b0;
      wptr       <= '0;
      cnt        <= '0;
      auto_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= PREFILL;
          wptr     <= '0;
          cnt      <= '0;
          auto_cnt <= '0;
        end

        PREFILL: begin
          if (bus.ad_valid) begin
            wptr <= wptr_nxt_c;
            prev <= bus.ad_data;
            if (cnt == AW'(PRE_TRIG - 1)) begin
              cnt   <= '0;
              state <= ARMED;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        ARMED: begin
          if (bus.ad_valid) begin
            wptr <= wptr_nxt_c;
            prev <= bus.ad_data;
            if (cross_c || auto_cnt == TW'(AUTO_TO - 1)) begin
              taddr      <= wptr;
              tflag_pend <= cross_c;
              auto_cnt   <= '0;
              cnt        <= '0;
              if (POST_LEN == 0) begin
                state      <= FULL;
                wave_ready <= 1'b1;
              end else begin
                state <= POST;
              end
            end else begin
              auto_cnt <= auto_cnt + TW'(1);
            end
          end
        end

        POST: begin
          if (bus.ad_valid) begin
            wptr <= wptr_nxt_c;
            if (cnt == AW'(POST_LEN - 1)) begin
              state      <= FULL;
              wave_ready <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        FULL: begin
          if (bus.wr_over) begin
            front       <= ~front;
            start       <= start_nxt_c;
            trig_flag   <= tflag_pend;
            front_valid <= 1'b1;
            wave_ready  <= 1'b0;
            state       <= PREFILL;
            wptr        <= '0;
            cnt         <= '0;
            auto_cnt    <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_buffer.sv
// tb_wave_buffer: directed bench for wave_buffer. Read expectations are queued
// when a column is requested and compared one cycle later.
module tb_wave_buffer;

  logic       lcd_clk;
  logic       sys_rst;
  logic       run_stop;
  logic [7:0] trig_level;
  logic       trig_edge;

  wave_buffer_if bus();

  wave_buffer #(.DEPTH(300), .PRE_TRIG(150), .AUTO_TO(4000)) dut (
    .lcd_clk    (lcd_clk),
    .sys_rst    (sys_rst),
    .run_stop   (run_stop),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .bus        (bus)
  );

  always #5 lcd_clk = ~lcd_clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_total;
  int  n_pass;
  int  cur_idx;
  int  mode;     // 0 ramp, 1 constant 50, 2 square 200/20
  int  sqbase;
  int  cap0;
  int  g;

  function automatic logic [7:0] gen(input int idx);
    logic [7:0] v;
    case (mode)
      0:       v = 8'(idx);
      1:       v = 8'd50;
      default: v = (((idx - sqbase) % 16) < 8) ? 8'd200 : 8'd20;
    endcase
    return v;
  endfunction

  // Ramp capture: column 150 holds the crossing value lvl
  function automatic logic [15:0] ramp_exp(input int c, input int lvl);
    int cc;
    logic [7:0] v;
    cc = (c > 299) ? 299 : c;
    v  = 8'(lvl + cc - 150);
    return {8'd0, v};
  endfunction

  // Square capture: column 150 is the first low sample (phase 8 of 16)
  function automatic logic [15:0] sq_exp(input int c);
    int cc;
    int p;
    cc = (c > 299) ? 299 : c;
    p  = (((8 + cc - 150) % 16) + 16) % 16;
    return (p < 8) ? 16'd200 : 16'd20;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge lcd_clk);
    #1;
    cur_idx++;
    bus.ad_data = gen(cur_idx);
  endtask

  task automatic drain();
    sb_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk(e.tag, 32'(bus.line_length), 32'(e.exp));
  endtask

  task automatic rd(input int col, input logic [15:0] e, input string tag);
    bus.data_req = 1'b1;
    bus.line_cnt = 9'(col);
    sb.push_back('{tag, e});
    step();
    drain();
  endtask

  task automatic rd_hold(input logic [15:0] e);
    bus.data_req = 1'b0;
    bus.line_cnt = 9'd3;
    sb.push_back('{"read_hold", e});
    step();
    drain();
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int k;
    k = 0;
    while (!bus.wave_ready && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(bus.wave_ready), 32'd1);
  endtask

  task automatic advance_to(input int target, input int budget);
    int k;
    k = 0;
    while (cur_idx < target && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic swap();
    bus.wr_over = 1'b1;
    step();
    bus.wr_over = 1'b0;
  endtask

  initial begin
    lcd_clk      = 1'b0;
    sys_rst      = 1'b1;
    run_stop     = 1'b0;
    trig_level   = 8'd100;
    trig_edge    = 1'b0;
    mode         = 0;
    sqbase       = 0;
    cur_idx      = 0;
    n_total      = 0;
    n_pass       = 0;
    bus.ad_data  = gen(0);
    bus.ad_valid = 1'b1;
    bus.data_req = 1'b0;
    bus.line_cnt = 9'd0;
    bus.wr_over  = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_line_length", 32'(bus.line_length), 32'd128);
    chk("rst_wave_ready", 32'(bus.wave_ready), 32'd0);
    chk("rst_trig_flag", 32'(bus.trig_flag), 32'd0);
    sys_rst = 1'b0;
    step();

    // Midline before any swap
    rd(10, 16'd128, "pre_swap_col10");
    rd(299, 16'd128, "pre_swap_col299");
    rd_hold(16'd128);

    // Rising trigger on a ramp
    run_stop = 1'b1;
    wait_ready(1500, "ramp_ready");
    step();
    chk("ramp_ready_holds", 32'(bus.wave_ready), 32'd1);
    swap();
    cap0 = cur_idx;
    chk("ramp_ready_fall", 32'(bus.wave_ready), 32'd0);
    chk("ramp_trig_flag", 32'(bus.trig_flag), 32'd1);
    rd(150, ramp_exp(150, 100), "ramp_col150");
    rd(149, ramp_exp(149, 100), "ramp_col149");
    rd(0, ramp_exp(0, 100), "ramp_col0");
    rd(299, ramp_exp(299, 100), "ramp_col299");
    rd(500, ramp_exp(500, 100), "ramp_col_clamp");
    rd_hold(ramp_exp(500, 100));

    // wr_over coincident with the last POST write is ignored
    trig_level = 8'd40;
    g = cap0 + 150;
    while ((g % 256) != 40) g++;
    advance_to(g + 149, 1000);
    chk("coinc_ready_before", 32'(bus.wave_ready), 32'd0);
    bus.wr_over = 1'b1;
    step();
    bus.wr_over = 1'b0;
    chk("coinc_ready_rise", 32'(bus.wave_ready), 32'd1);
    rd(150, ramp_exp(150, 100), "coinc_no_swap_col150");
    swap();
    chk("coinc_ready_fall", 32'(bus.wave_ready), 32'd0);
    chk("coinc_trig_flag", 32'(bus.trig_flag), 32'd1);
    rd(150, ramp_exp(150, 40), "coinc_swap_col150");
    rd(0, ramp_exp(0, 40), "coinc_swap_col0");
    rd(299, ramp_exp(299, 40), "coinc_swap_col299");
    rd_hold(ramp_exp(299, 40));

    // Falling trigger on a square wave
    run_stop = 1'b0;
    step();
    chk("stop_idle_ready", 32'(bus.wave_ready), 32'd0);
    mode        = 2;
    trig_edge   = 1'b1;
    trig_level  = 8'd100;
    sqbase      = cur_idx;
    bus.ad_data = gen(cur_idx);
    run_stop    = 1'b1;
    wait_ready(1500, "sq_ready");
    swap();
    cap0 = cur_idx;
    chk("sq_trig_flag", 32'(bus.trig_flag), 32'd1);
    rd(150, sq_exp(150), "sq_col150");
    rd(149, sq_exp(149), "sq_col149");
    rd(0, sq_exp(0), "sq_col0");
    rd(157, sq_exp(157), "sq_col157");
    rd(158, sq_exp(158), "sq_col158");
    rd(299, sq_exp(299), "sq_col299");
    rd_hold(sq_exp(299));

    // run_stop dropped mid-POST aborts the capture, display frozen
    g = cap0 + 150;
    while (((g - sqbase) % 16) != 8) g++;
    advance_to(g + 50, 1000);
    run_stop = 1'b0;
    step();
    chk("stop_post_ready", 32'(bus.wave_ready), 32'd0);
    repeat (400) step();
    chk("stop_post_ready_late", 32'(bus.wave_ready), 32'd0);
    chk("stop_post_trig_flag", 32'(bus.trig_flag), 32'd1);
    rd(150, sq_exp(150), "stop_post_col150");
    rd(149, sq_exp(149), "stop_post_col149");
    rd_hold(sq_exp(149));

    // Auto trigger on a constant input
    mode        = 1;
    trig_edge   = 1'b0;
    trig_level  = 8'd100;
    bus.ad_data = gen(cur_idx);
    run_stop    = 1'b1;
    step();
    cap0 = cur_idx;
    advance_to(cap0 + 4298, 5000);
    chk("auto_ready_before", 32'(bus.wave_ready), 32'd0);
    step();
    chk("auto_ready_rise", 32'(bus.wave_ready), 32'd1);
    swap();
    chk("auto_trig_flag", 32'(bus.trig_flag), 32'd0);
    rd(0, 16'd50, "auto_col0");
    rd(150, 16'd50, "auto_col150");
    rd(299, 16'd50, "auto_col299");
    rd_hold(16'd50);

    // Reset during ARMED, then a fresh capture
    repeat (200) step();
    sys_rst = 1'b1;
    step();
    chk("armed_rst_line_length", 32'(bus.line_length), 32'd128);
    chk("armed_rst_wave_ready", 32'(bus.wave_ready), 32'd0);
    chk("armed_rst_trig_flag", 32'(bus.trig_flag), 32'd0);
    sys_rst     = 1'b0;
    mode        = 0;
    trig_level  = 8'd100;
    trig_edge   = 1'b0;
    bus.ad_data = gen(cur_idx);
    rd(20, 16'd128, "post_rst_col20");
    rd_hold(16'd128);
    wait_ready(1500, "post_rst_ready");
    swap();
    chk("post_rst_trig_flag", 32'(bus.trig_flag), 32'd1);
    rd(150, ramp_exp(150, 100), "post_rst_col150");
    rd(149, ramp_exp(149, 100), "post_rst_col149");
    rd(0, ramp_exp(0, 100), "post_rst_col0");
    rd_hold(ramp_exp(0, 100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
